boot_ram_arbiter: RTL and testbench

- Shares the single-port 8x2K boot RAM (SP primitive wrapper: 11-bit address, 8-bit data, 1-cycle read latency, bypass read mode) between two requesters.
  - Port A: soft-CPU instruction/data fetch.
  - Port B: UART/debug boot loader.
- After reset, a BOOT phase gives the loader exclusive access. The CPU is released on loader handoff.
- In the RUN phase, requests are round-robin arbitrated with a burst cap. Read data is routed back to the owning port.

---
 rtl/boot_ram_arbiter_if.sv | 36 +++
 rtl/boot_ram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_boot_ram_arbiter.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_ram_arbiter_if.sv
// Requester-side bus for boot_ram_arbiter: CPU port (a_*) and loader port (b_*).
// The arbiter connects through the slave modport; the requesters (or a bench) use master.
interface boot_ram_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 8
) ();
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata
  );
endinterface

// File: rtl/boot_ram_arbiter.sv
// boot_ram_arbiter: shares a single-port boot RAM (1-cycle read latency) between the
// soft-CPU (port A) and the boot loader (port B). BOOT phase gives B exclusive access
// until b_done; RUN phase arbitrates round-robin with a burst cap of MAX_BURST.
// Optional macro BOOT_RAM_WP_EN: RUN-phase CPU writes are acknowledged but suppressed
// at the RAM, and flagged on the sticky a_wp_err output.
module boot_ram_arbiter #(
  parameter int AW        = 11,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int BOOT_HOLD = 1
) (
  input  logic                clk,
  input  logic                reset,
  boot_ram_arbiter_if.slave   bus,
  input  logic                b_done,
  output logic                cpu_run,
  output logic                ram_ce,
  output logic                ram_oce,
  output logic                ram_wre,
  output logic [AW-1:0]       ram_ad,
  output logic [DW-1:0]       ram_din,
  input  logic [DW-1:0]       ram_dout,
  output logic                ram_reset
`ifdef BOOT_RAM_WP_EN
  ,
  output logic                a_wp_err
`endif
);

  typedef enum logic { PH_BOOT = 1'b0, PH_RUN = 1'b1 } phase_t;
  typedef enum logic { OWN_A = 1'b0, OWN_B = 1'b1 } owner_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  phase_t        phase_r;
  owner_t        owner_r;
  owner_t        rd_owner_r;
  logic [3:0]    burst_r;
  logic          rd_valid_r;
  logic [DW-1:0] a_hold_r;
  logic [DW-1:0] b_hold_r;

  logic          a_req_eff_s;
  logic          b_req_eff_s;
  logic          a_win_s;
  logic          b_win_s;
  logic          a_wp_hit_s;

  // Grant selection: BOOT hides the CPU, RUN keeps the owner until its burst cap.
  always_comb begin
    a_req_eff_s = bus.a_req && (phase_r == PH_RUN) && !reset;
    b_req_eff_s = bus.b_req && !reset;
    a_win_s     = 1'b0;
    b_win_s     = 1'b0;
    if (a_req_eff_s && b_req_eff_s) begin
      if (owner_r == OWN_A) begin
        if (burst_r < MAX_B) begin
          a_win_s = 1'b1;
        end else begin
          b_win_s = 1'b1;
        end
      end else begin
        if (burst_r < MAX_B) begin
          b_win_s = 1'b1;
        end else begin
          a_win_s = 1'b1;
        end
      end
    end else if (a_req_eff_s) begin
      a_win_s = 1'b1;
    end else if (b_req_eff_s) begin
      b_win_s = 1'b1;
    end else begin
      a_win_s = 1'b0;
      b_win_s = 1'b0;
    end
  end

`ifdef BOOT_RAM_WP_EN
  // CPU grants only exist in RUN, so any granted CPU write is a protected write.
  assign a_wp_hit_s = a_win_s && bus.a_we;
`else
  assign a_wp_hit_s = 1'b0;
`endif

  // RAM command mux: address and data of the granted port, zero when idle.
  always_comb begin
    ram_ad  = {AW{1'b0}};
    ram_din = {DW{1'b0}};
    if (a_win_s) begin
      ram_ad  = bus.a_addr;
      ram_din = bus.a_wdata;
    end else if (b_win_s) begin
      ram_ad  = bus.b_addr;
      ram_din = bus.b_wdata;
    end else begin
      ram_ad  = {AW{1'b0}};
      ram_din = {DW{1'b0}};
    end
  end

  assign bus.a_gnt    = a_win_s;
  assign bus.b_gnt    = b_win_s;
  assign ram_ce       = a_win_s | b_win_s;
  assign ram_wre      = (a_win_s && bus.a_we && !a_wp_hit_s) || (b_win_s && bus.b_we);
  assign ram_oce      = 1'b1;
  assign ram_reset    = reset;
  assign cpu_run      = (phase_r == PH_RUN);

  assign bus.a_rvalid = rd_valid_r && (rd_owner_r == OWN_A);
  assign bus.b_rvalid = rd_valid_r && (rd_owner_r == OWN_B);
  assign bus.a_rdata  = bus.a_rvalid ? ram_dout : a_hold_r;
  assign bus.b_rdata  = bus.b_rvalid ? ram_dout : b_hold_r;

  // Phase, ownership/burst tracking, read-return tracking and held read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_r    <= (BOOT_HOLD != 0) ? PH_BOOT : PH_RUN;
      owner_r    <= OWN_B;
      burst_r    <= 4'd0;
      rd_valid_r <= 1'b0;
      rd_owner_r <= OWN_A;
      a_hold_r   <= {DW{1'b0}};
      b_hold_r   <= {DW{1'b0}};
    end else begin
      if ((phase_r == PH_BOOT) && b_done) begin
        phase_r <= PH_RUN;
      end

      if (a_win_s) begin
        if (owner_r != OWN_A) begin
          burst_r <= 4'd1;
        end else if (b_req_eff_s && (burst_r < MAX_B)) begin
          burst_r <= burst_r + 4'd1;
        end
        owner_r <= OWN_A;
      end else if (b_win_s) begin
        if (owner_r != OWN_B) begin
          burst_r <= 4'd1;
        end else if (a_req_eff_s && (burst_r < MAX_B)) begin
          burst_r <= burst_r + 4'd1;
        end
        owner_r <= OWN_B;
      end else begin
        burst_r <= 4'd0;
      end

      rd_valid_r <= (a_win_s && !bus.a_we) || (b_win_s && !bus.b_we);
      rd_owner_r <= b_win_s ? OWN_B : OWN_A;

      if (bus.a_rvalid) begin
        a_hold_r <= ram_dout;
      end
      if (bus.b_rvalid) begin
        b_hold_r <= ram_dout;
      end
    end
  end

`ifdef BOOT_RAM_WP_EN
  // Sticky write-protect violation flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_wp_err <= 1'b0;
    end else if (a_wp_hit_s) begin
      a_wp_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_boot_ram_arbiter.sv
// Self-checking bench for boot_ram_arbiter with a behavioural RAM and reference model.
// Build with BOOT_RAM_WP_EN defined to also exercise the write-protect feature.
module tb_boot_ram_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int MAX_BURST = 4;
`ifdef BOOT_RAM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          b_done = 1'b0;
  logic          cpu_run, ram_ce, ram_oce, ram_wre, ram_reset;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = 8'h00;
`ifdef BOOT_RAM_WP_EN
  logic          a_wp_err;
`endif

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] ram_mem [0:2047];
  logic [DW-1:0] ref_mem [0:2047];
  bit            ram_loaded = 1'b0;

  boot_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  boot_ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .BOOT_HOLD(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .b_done    (b_done),
    .cpu_run   (cpu_run),
    .ram_ce    (ram_ce),
    .ram_oce   (ram_oce),
    .ram_wre   (ram_wre),
    .ram_ad    (ram_ad),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .ram_reset (ram_reset)
`ifdef BOOT_RAM_WP_EN
    ,
    .a_wp_err  (a_wp_err)
`endif
  );

  always #5 clk = ~clk;

  // Single-port RAM model: 1-cycle read latency, normal write mode, preloaded contents.
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 2048; i++) ram_mem[i] <= 8'(i * 7);
      ram_loaded <= 1'b1;
    end else if (ram_ce) begin
      if (ram_wre) ram_mem[ram_ad] <= ram_din;
      else         ram_dout <= ram_mem[ram_ad];
    end
  end

  task automatic idle_inputs();
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = 11'h000; bus.a_wdata = 8'h00;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 11'h000; bus.b_wdata = 8'h00;
    b_done = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in RUN with owner B and an idle (zero) burst history.
  task automatic reset_to_run();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    b_done = 1'b1;
    next_cycle();
    b_done = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bus.b_req = 1'b1;
    #1;
    checks++;
    if ({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, ram_ce, ram_wre, cpu_run} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000000", {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, ram_ce, ram_wre, cpu_run});
    end
    checks++;
    if ({bus.a_rdata, bus.b_rdata, ram_ad, ram_din} !== 35'h0) begin
      failures++;
      $display("FAIL reset_data: got %h want 0", {bus.a_rdata, bus.b_rdata, ram_ad, ram_din});
    end
    checks++;
    if ({ram_oce, ram_reset} !== 2'b11) begin
      failures++;
      $display("FAIL reset_ties: got %b want 11", {ram_oce, ram_reset});
    end
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    #1;
    checks++;
    if ({ram_reset, cpu_run} !== 2'b00) begin
      failures++;
      $display("FAIL reset_release: got %b want 00", {ram_reset, cpu_run});
    end
  endtask

  task automatic test_boot();
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 11'h000;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 11'h123; bus.b_wdata = 8'h5A;
    #1;
    checks++;
    if ({bus.a_gnt, bus.b_gnt, ram_ce, ram_wre, cpu_run} !== 5'b01110) begin
      failures++;
      $display("FAIL boot_b_write: got %b want 01110", {bus.a_gnt, bus.b_gnt, ram_ce, ram_wre, cpu_run});
    end
    checks++;
    if ({ram_ad, ram_din} !== {11'h123, 8'h5A}) begin
      failures++;
      $display("FAIL boot_bus: got %h want %h", {ram_ad, ram_din}, {11'h123, 8'h5A});
    end
    next_cycle();
    ref_mem[11'h123] = 8'h5A;
    bus.b_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.a_gnt, bus.b_rvalid, cpu_run} !== 3'b000) begin
        failures++;
        $display("FAIL boot_a_held: got %b want 000", {bus.a_gnt, bus.b_rvalid, cpu_run});
      end
      next_cycle();
    end
    b_done = 1'b1;
    #1;
    checks++;
    if ({bus.a_gnt, cpu_run} !== 2'b00) begin
      failures++;
      $display("FAIL boot_done_cycle: got %b want 00", {bus.a_gnt, cpu_run});
    end
    next_cycle();
    b_done = 1'b0;
    #1;
    checks++;
    if ({cpu_run, bus.a_gnt, ram_wre, ram_ad} !== {3'b110, 11'h000}) begin
      failures++;
      $display("FAIL boot_release: got %h want %h", {cpu_run, bus.a_gnt, ram_wre, ram_ad}, {3'b110, 11'h000});
    end
    next_cycle();
    bus.a_req = 1'b0;
    checks++;
    if ({bus.a_rvalid, bus.b_rvalid, bus.a_rdata} !== {2'b10, ref_mem[11'h000]}) begin
      failures++;
      $display("FAIL boot_first_read: got %h want %h", {bus.a_rvalid, bus.b_rvalid, bus.a_rdata}, {2'b10, ref_mem[11'h000]});
    end
  endtask

  task automatic test_read_route();
    reset_to_run();
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 11'h123; bus.b_wdata = 8'h5A;
    #1;
    checks++;
    if ({bus.a_gnt, bus.b_gnt, ram_wre} !== 3'b011) begin
      failures++;
      $display("FAIL route_b_write: got %b want 011", {bus.a_gnt, bus.b_gnt, ram_wre});
    end
    next_cycle();
    ref_mem[11'h123] = 8'h5A;
    bus.b_req = 1'b0;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 11'h123;
    #1;
    checks++;
    if ({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid} !== 4'b1000) begin
      failures++;
      $display("FAIL route_a_grant: got %b want 1000", {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid});
    end
    next_cycle();
    bus.a_req = 1'b0;
    checks++;
    if ({bus.a_rvalid, bus.b_rvalid, bus.a_rdata} !== {2'b10, 8'h5A}) begin
      failures++;
      $display("FAIL route_a_read: got %h want %h", {bus.a_rvalid, bus.b_rvalid, bus.a_rdata}, {2'b10, 8'h5A});
    end
    next_cycle();
    checks++;
    if ({bus.a_rvalid, bus.a_rdata, bus.b_rdata} !== {1'b0, 8'h5A, 8'h00}) begin
      failures++;
      $display("FAIL route_hold: got %h want %h", {bus.a_rvalid, bus.a_rdata, bus.b_rdata}, {1'b0, 8'h5A, 8'h00});
    end
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 11'h200; bus.b_wdata = 8'h77;
    next_cycle();
    ref_mem[11'h200] = 8'h77;
    bus.b_we = 1'b0;
    next_cycle();
    bus.b_req = 1'b0;
    checks++;
    if ({bus.a_rvalid, bus.b_rvalid, bus.b_rdata, bus.a_rdata} !== {2'b01, 8'h77, 8'h5A}) begin
      failures++;
      $display("FAIL route_rdw: got %h want %h", {bus.a_rvalid, bus.b_rvalid, bus.b_rdata, bus.a_rdata}, {2'b01, 8'h77, 8'h5A});
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g;
    reset_to_run();
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 11'h010;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 11'h020;
    for (int k = 0; k < 24; k++) begin
      // Last owner after reset is B, so B opens with a full burst, then ownership alternates.
      exp_g = (((k / MAX_BURST) % 2) == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if ({bus.a_gnt, bus.b_gnt} !== exp_g) begin
        failures++;
        $display("FAIL fair_grant[%0d]: got %b want %b", k, {bus.a_gnt, bus.b_gnt}, exp_g);
      end
      next_cycle();
      checks++;
      if ({bus.a_rvalid, bus.b_rvalid, exp_g[1] ? bus.a_rdata : bus.b_rdata} !==
          {exp_g, exp_g[1] ? ref_mem[11'h010] : ref_mem[11'h020]}) begin
        failures++;
        $display("FAIL fair_rvalid[%0d]: got %b want %b", k, {bus.a_rvalid, bus.b_rvalid}, exp_g);
      end
    end
    idle_inputs();
  endtask

  task automatic test_stream();
    logic [AW-1:0] addrs [3];
    addrs[0] = 11'h7FE; addrs[1] = 11'h7FF; addrs[2] = 11'h000;
    reset_to_run();
    bus.a_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        checks++;
        if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, ref_mem[addrs[i-1]]}) begin
          failures++;
          $display("FAIL stream_data[%0d]: got %h want %h", i - 1, {bus.a_rvalid, bus.a_rdata}, {1'b1, ref_mem[addrs[i-1]]});
        end
      end
      if (i < 3) begin
        bus.a_req = 1'b1;
        bus.a_addr = addrs[i];
        #1;
        checks++;
        if ({bus.a_gnt, ram_ad} !== {1'b1, addrs[i]}) begin
          failures++;
          $display("FAIL stream_grant[%0d]: got %h want %h", i, {bus.a_gnt, ram_ad}, {1'b1, addrs[i]});
        end
        next_cycle();
      end else begin
        bus.a_req = 1'b0;
      end
    end
    next_cycle();
    checks++;
    if (bus.a_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL stream_end: got %b want 0", bus.a_rvalid);
    end
  endtask

  task automatic test_random();
    bit pa, pb, nva, nvb, exp_wre;
    logic wa, wb;
    logic [AW-1:0] ada, adb, exp_ad;
    logic [DW-1:0] da, db, exp_din, exp_ra, exp_rb;
    logic [1:0] exp_g;
    int owner, cnt, win;
    reset_to_run();
    pa = 1'b0; pb = 1'b0; owner = 1; cnt = 0;
    exp_ra = 8'h00; exp_rb = 8'h00;
    wa = 1'b0; wb = 1'b0; ada = 11'h000; adb = 11'h000; da = 8'h00; db = 8'h00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pa && ($urandom_range(0, 2) != 0)) begin
        pa = 1'b1; wa = 1'($urandom_range(0, 1)); ada = 11'($urandom_range(0, 15)); da = 8'($urandom);
      end
      if (!pb && ($urandom_range(0, 2) != 0)) begin
        pb = 1'b1; wb = 1'($urandom_range(0, 1)); adb = 11'($urandom_range(0, 15)); db = 8'($urandom);
      end
      bus.a_req = pa; bus.a_we = wa; bus.a_addr = ada; bus.a_wdata = da;
      bus.b_req = pb; bus.b_we = wb; bus.b_addr = adb; bus.b_wdata = db;
      b_done = ($urandom_range(0, 7) == 0);
      #1;
      // Reference arbitration: the last owner may continue while under the cap.
      if (pa && pb)  win = (cnt < MAX_BURST) ? owner : 1 - owner;
      else if (pa)   win = 0;
      else if (pb)   win = 1;
      else           win = -1;
      exp_g   = (win == 0) ? 2'b10 : ((win == 1) ? 2'b01 : 2'b00);
      exp_wre = (win == 0) ? (wa && !WP) : ((win == 1) ? wb : 1'b0);
      exp_ad  = (win == 0) ? ada : ((win == 1) ? adb : 11'h000);
      exp_din = (win == 0) ? da : ((win == 1) ? db : 8'h00);
      checks++;
      if ({bus.a_gnt, bus.b_gnt, ram_ce, ram_wre, ram_ad, ram_din, cpu_run} !==
          {exp_g, (win >= 0), exp_wre, exp_ad, exp_din, 1'b1}) begin
        failures++;
        $display("FAIL rand_cmd[%0d]: got %h want %h", cyc,
                 {bus.a_gnt, bus.b_gnt, ram_ce, ram_wre, ram_ad, ram_din, cpu_run},
                 {exp_g, (win >= 0), exp_wre, exp_ad, exp_din, 1'b1});
      end
      if (win < 0)                     cnt = 0;
      else if (win != owner)           cnt = 1;
      else if (win == 0 ? pb : pa)     cnt = (cnt < MAX_BURST) ? cnt + 1 : cnt;
      if (win >= 0) owner = win;
      nva = 1'b0; nvb = 1'b0;
      if (win == 0) begin
        if (wa) begin
          if (!WP) ref_mem[ada] = da;
        end else begin
          nva = 1'b1; exp_ra = ref_mem[ada];
        end
        pa = 1'b0;
      end else if (win == 1) begin
        if (wb) ref_mem[adb] = db;
        else begin
          nvb = 1'b1; exp_rb = ref_mem[adb];
        end
        pb = 1'b0;
      end
      next_cycle();
      checks++;
      if ({bus.a_rvalid, bus.b_rvalid, bus.a_rdata, bus.b_rdata} !== {nva, nvb, exp_ra, exp_rb}) begin
        failures++;
        $display("FAIL rand_ret[%0d]: got %h want %h", cyc,
                 {bus.a_rvalid, bus.b_rvalid, bus.a_rdata, bus.b_rdata}, {nva, nvb, exp_ra, exp_rb});
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    reset_to_run();
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 11'h123;
    #1;
    checks++;
    if (bus.a_gnt !== 1'b1) begin
      failures++;
      $display("FAIL midrst_grant: got %b want 1", bus.a_gnt);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.a_gnt, bus.b_gnt, ram_ce, ram_wre, cpu_run, bus.a_rvalid, ram_ad} !== {6'b0, 11'h000}) begin
      failures++;
      $display("FAIL midrst_async: got %h want 0", {bus.a_gnt, bus.b_gnt, ram_ce, ram_wre, cpu_run, bus.a_rvalid, ram_ad});
    end
    next_cycle();
    bus.a_req = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.a_rvalid, bus.a_rdata} !== 9'h000) begin
        failures++;
        $display("FAIL midrst_norv[%0d]: got %h want 000", i, {bus.a_rvalid, bus.a_rdata});
      end
      next_cycle();
    end
    reset_to_run();
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 11'h123;
    @(posedge clk);
    reset = 1'b1;
    bus.a_req = 1'b0;
    #1;
    checks++;
    if ({bus.a_rvalid, bus.a_rdata} !== 9'h000) begin
      failures++;
      $display("FAIL midrst_inflight: got %h want 000", {bus.a_rvalid, bus.a_rdata});
    end
    next_cycle();
    reset = 1'b0;
    next_cycle();
    checks++;
    if (bus.a_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_after: got %b want 0", bus.a_rvalid);
    end
  endtask

`ifdef BOOT_RAM_WP_EN
  task automatic test_wp();
    logic [DW-1:0] old_v;
    reset_to_run();
    old_v = ref_mem[11'h010];
    checks++;
    if (a_wp_err !== 1'b0) begin
      failures++;
      $display("FAIL wp_reset: got %b want 0", a_wp_err);
    end
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 11'h010; bus.a_wdata = 8'hFF;
    #1;
    checks++;
    if ({bus.a_gnt, ram_ce, ram_wre} !== 3'b110) begin
      failures++;
      $display("FAIL wp_write: got %b want 110", {bus.a_gnt, ram_ce, ram_wre});
    end
    next_cycle();
    bus.a_we = 1'b0;
    checks++;
    if (a_wp_err !== 1'b1) begin
      failures++;
      $display("FAIL wp_flag: got %b want 1", a_wp_err);
    end
    next_cycle();
    bus.a_req = 1'b0;
    checks++;
    if ({bus.a_rvalid, bus.a_rdata, a_wp_err} !== {1'b1, old_v, 1'b1}) begin
      failures++;
      $display("FAIL wp_old_data: got %h want %h", {bus.a_rvalid, bus.a_rdata, a_wp_err}, {1'b1, old_v, 1'b1});
    end
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 11'h030; bus.b_wdata = 8'h11;
    #1;
    checks++;
    if ({bus.b_gnt, ram_wre, a_wp_err} !== 3'b111) begin
      failures++;
      $display("FAIL wp_b_write: got %b want 111", {bus.b_gnt, ram_wre, a_wp_err});
    end
    next_cycle();
    ref_mem[11'h030] = 8'h11;
    bus.b_req = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'(i * 7);
    test_reset();
    test_boot();
    test_read_route();
    test_fairness();
    test_stream();
    test_random();
    test_reset_mid_read();
`ifdef BOOT_RAM_WP_EN
    test_wp();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
